umtrx_rx_sample_framer: RTL and testbench

Receive-direction counterpart of the TX VITA deframer. Takes decimated 32-bit IQ samples from the DDC chain (sample + strobe) and the VITA time in the dsp clock domain. Packs them into VITA-49 IF data packets (header, stream ID, 64-bit timestamp, N samples) on a 36-bit framed stream with src/dst ready handshake. Sits between the DDC chain and the sys-domain clock-crossing FIFO. Drops whole packets, never partial ones, on overflow.

---
 rtl/umtrx_rx_sample_framer_pkg.sv | 17 +
 rtl/umtrx_rx_sample_framer_fifo.sv | 37 +++
 rtl/umtrx_rx_sample_framer.sv | 118 +++++++++++
 tb/tb_umtrx_rx_sample_framer.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/umtrx_rx_sample_framer_pkg.sv
// umtrx_rx_sample_framer_pkg: shared constants, header record and reader states for the RX sample framer
package umtrx_rx_sample_framer_pkg;
  localparam int SR_SPP = 0;
  localparam int SR_SID = 1;
  localparam int SR_CTRL = 2;
  localparam logic [3:0] PKT_TYPE_IF_SID = 4'h1;
  localparam logic [1:0] TSF_SAMPLE_CNT = 2'b01;
  localparam int HDR_WORDS = 4;
  localparam int SOF = 32;
  localparam int EOF = 33;
  typedef enum logic [2:0] {IDLE, HDR0, HDR1, HDR2, HDR3, PAYLOAD} state_t;
  typedef struct packed {
    logic [3:0] seq;
    logic [15:0] spp;
    logic [63:0] ts;
  } hdr_t;
endpackage

// File: rtl/umtrx_rx_sample_framer_fifo.sv
// rx_sync_fifo: single-clock show-ahead FIFO with occupancy count and full/empty flags
module rx_sync_fifo #(
  parameter int W = 32,
  parameter int AW = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic wr,
  input  logic [W-1:0] din,
  input  logic rd,
  output logic [W-1:0] dout,
  output logic [AW:0] count,
  output logic full,
  output logic empty
);
  logic [W-1:0] mem [2**AW];
  logic [AW-1:0] wp, rp;
  logic do_wr, do_rd;
  assign full = count == (AW+1)'(2**AW);
  assign empty = count == '0;
  assign do_wr = wr && !full;
  assign do_rd = rd && !empty;
  assign dout = mem[rp];
  always_ff @(posedge clk)
    if (do_wr) mem[wp] <= din;
  always_ff @(posedge clk)
    if (!rst_n || clr) begin
      wp <= '0;
      rp <= '0;
      count <= '0;
    end else begin
      if (do_wr) wp <= wp + 1'b1;
      if (do_rd) rp <= rp + 1'b1;
      count <= count + (AW+1)'(do_wr) - (AW+1)'(do_rd);
    end
endmodule

// File: rtl/umtrx_rx_sample_framer.sv
// umtrx_rx_sample_framer: packs strobed IQ samples into VITA-49 IF data packets on a 36-bit framed stream
module umtrx_rx_sample_framer
  import umtrx_rx_sample_framer_pkg::*;
#(
  parameter int BASE = 0,
  parameter int FIFOSIZE = 9,
  parameter int HDR_FIFOSIZE = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic set_stb,
  input  logic [7:0] set_addr,
  input  logic [31:0] set_data,
  input  logic [31:0] sample,
  input  logic strobe,
  input  logic [63:0] vita_time,
  output logic [35:0] rx_data_o,
  output logic rx_src_rdy_o,
  input  logic rx_dst_rdy_i,
  output logic run,
  output logic overflow,
  output logic [15:0] overflow_count
);
  localparam logic [7:0] A_SPP = 8'(BASE + SR_SPP);
  localparam logic [7:0] A_SID = 8'(BASE + SR_SID);
  localparam logic [7:0] A_CTRL = 8'(BASE + SR_CTRL);
  localparam logic [15:0] MAX_SPP = 16'(2**FIFOSIZE);
  logic [15:0] spp, spp_eff, rem, pcnt;
  logic [31:0] sid, d;
  logic [3:0] seq;
  logic enable, clr, open, drop, start, accept;
  logic s_wr, s_rd, s_full, s_empty, h_full, h_empty, h_rd, last;
  logic [31:0] s_dout;
  logic [FIFOSIZE:0] s_count;
  logic [HDR_FIFOSIZE:0] h_count;
  hdr_t hdr_in, hdr_q;
  state_t state, nxt;
  assign clr = set_stb && set_addr == A_CTRL && set_data[1];
  assign spp_eff = spp == 16'd0 ? 16'd1 : spp > MAX_SPP ? MAX_SPP : spp;
  assign start = strobe && enable && !open;
  assign accept = !h_full && 17'(2**FIFOSIZE) - 17'(s_count) >= {1'b0, spp_eff};
  assign s_wr = strobe && !s_full && (start ? accept : open && !drop);
  assign hdr_in = '{seq: seq, spp: spp_eff, ts: vita_time};
  assign last = pcnt == hdr_q.spp - 16'd1;
  assign s_rd = state == PAYLOAD && !s_empty && rx_dst_rdy_i;
  assign h_rd = s_rd && last && !h_empty;
  assign run = enable || open;
  always_ff @(posedge clk)
    if (!rst_n) begin
      spp <= 16'd1;
      sid <= '0;
      enable <= 1'b0;
    end else if (set_stb) begin
      if (set_addr == A_SPP) spp <= set_data[15:0];
      if (set_addr == A_SID) sid <= set_data;
      if (set_addr == A_CTRL) enable <= set_data[0];
    end
  always_ff @(posedge clk)
    if (!rst_n || clr) begin
      open <= 1'b0;
      drop <= 1'b0;
      rem <= '0;
      seq <= '0;
      overflow <= 1'b0;
      overflow_count <= '0;
    end else begin
      overflow <= start && !accept;
      if (start && !accept) overflow_count <= overflow_count + 16'd1;
      if (start && accept) seq <= seq + 4'd1;
      if (start) begin
        open <= spp_eff != 16'd1;
        drop <= !accept;
        rem <= spp_eff - 16'd1;
      end else if (open && strobe) begin
        open <= rem != 16'd1;
        rem <= rem - 16'd1;
      end
    end
  rx_sync_fifo #(.W(32), .AW(FIFOSIZE)) u_samples (
    .clk(clk), .rst_n(rst_n), .clr(clr), .wr(s_wr), .din(sample), .rd(s_rd),
    .dout(s_dout), .count(s_count), .full(s_full), .empty(s_empty)
  );
  rx_sync_fifo #(.W($bits(hdr_t)), .AW(HDR_FIFOSIZE)) u_headers (
    .clk(clk), .rst_n(rst_n), .clr(clr), .wr(start && accept), .din(hdr_in), .rd(h_rd),
    .dout(hdr_q), .count(h_count), .full(h_full), .empty(h_empty)
  );
  always_ff @(posedge clk)
    if (!rst_n || clr) begin
      state <= IDLE;
      pcnt <= '0;
    end else begin
      state <= nxt;
      if (s_rd) pcnt <= last ? '0 : pcnt + 16'd1;
    end
  always_comb begin
    nxt = state;
    case (state)
      IDLE: nxt = h_count != '0 ? HDR0 : IDLE;
      HDR0: nxt = rx_dst_rdy_i ? HDR1 : HDR0;
      HDR1: nxt = rx_dst_rdy_i ? HDR2 : HDR1;
      HDR2: nxt = rx_dst_rdy_i ? HDR3 : HDR2;
      HDR3: nxt = rx_dst_rdy_i ? PAYLOAD : HDR3;
      PAYLOAD: nxt = s_rd && last ? IDLE : PAYLOAD;
      default: nxt = IDLE;
    endcase
  end
  always_comb begin
    d = state == HDR0 ? {PKT_TYPE_IF_SID, 4'h0, 2'b00, TSF_SAMPLE_CNT, hdr_q.seq, 16'(hdr_q.spp + 16'(HDR_WORDS))}
      : state == HDR1 ? sid
      : state == HDR2 ? hdr_q.ts[63:32]
      : state == HDR3 ? hdr_q.ts[31:0]
      : state == PAYLOAD ? s_dout : '0;
    rx_data_o = {4'b0000, d};
    rx_data_o[SOF] = state == HDR0;
    rx_data_o[EOF] = state == PAYLOAD && last;
    rx_src_rdy_o = state == PAYLOAD ? !s_empty : state != IDLE;
  end
endmodule

// File: tb/tb_umtrx_rx_sample_framer.sv
// tb_umtrx_rx_sample_framer: directed self-checking bench for the RX sample framer
module tb_umtrx_rx_sample_framer;
  import umtrx_rx_sample_framer_pkg::*;
  logic clk = 1'b0;
  logic rst_n, set_stb, strobe, rx_src_rdy_o, rx_dst_rdy_i, run, overflow;
  logic [7:0] set_addr;
  logic [31:0] set_data, sample;
  logic [63:0] vita_time;
  logic [35:0] rx_data_o;
  logic [15:0] overflow_count;
  int checks = 0, failures = 0, rdy_mode = 0, ovf_pulses = 0;
  logic [35:0] q[$];
  logic stall_pend = 1'b0;
  logic [35:0] stall_word;
  logic found;
  umtrx_rx_sample_framer #(.BASE(0), .FIFOSIZE(4), .HDR_FIFOSIZE(2)) dut (
    .clk(clk), .rst_n(rst_n), .set_stb(set_stb), .set_addr(set_addr), .set_data(set_data),
    .sample(sample), .strobe(strobe), .vita_time(vita_time), .rx_data_o(rx_data_o),
    .rx_src_rdy_o(rx_src_rdy_o), .rx_dst_rdy_i(rx_dst_rdy_i), .run(run),
    .overflow(overflow), .overflow_count(overflow_count)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  always @(negedge clk) begin
    if (stall_pend) check("stall_hold", 64'({rx_src_rdy_o, rx_data_o}), 64'({1'b1, stall_word}));
    stall_pend = rst_n && rx_src_rdy_o && !rx_dst_rdy_i;
    stall_word = rx_data_o;
    if (rst_n && rx_src_rdy_o && rx_dst_rdy_i) q.push_back(rx_data_o);
    if (overflow) ovf_pulses++;
  end
  task automatic tick();
    @(posedge clk);
    #1;
    if (rdy_mode == 0) rx_dst_rdy_i = 1'b1;
    else if (rdy_mode == 1) rx_dst_rdy_i = !rx_dst_rdy_i;
    else if (rdy_mode == 2) rx_dst_rdy_i = 1'b0;
  endtask
  task automatic write_reg(input logic [7:0] a, input logic [31:0] v);
    set_stb = 1'b1;
    set_addr = a;
    set_data = v;
    tick();
    set_stb = 1'b0;
  endtask
  task automatic send(input logic [31:0] s, input logic [63:0] t);
    sample = s;
    vita_time = t;
    strobe = 1'b1;
    tick();
    strobe = 1'b0;
  endtask
  task automatic wait_words(input int n);
    int k;
    k = 0;
    while (q.size() < n && k < 400) begin
      tick();
      k++;
    end
    repeat (8) tick();
    check("word_count", 64'(q.size()), 64'(n));
  endtask
  function automatic logic [35:0] wq(input int i);
    return i < q.size() ? q[i] : 36'hF_FFFF_FFFF;
  endfunction
  task automatic check_pkt(input string tag, input int b, input logic [3:0] seq, input logic [15:0] spp,
                           input logic [31:0] sid, input logic [63:0] ts, input logic [31:0] s0);
    logic [15:0] size;
    size = spp + 16'd4;
    check($sformatf("%s_hdr0", tag), 64'(wq(b)), 64'({4'b0001, 4'h1, 4'h0, 4'h1, seq, size}));
    check($sformatf("%s_sid", tag), 64'(wq(b + 1)), 64'({4'b0000, sid}));
    check($sformatf("%s_tsh", tag), 64'(wq(b + 2)), 64'({4'b0000, ts[63:32]}));
    check($sformatf("%s_tsl", tag), 64'(wq(b + 3)), 64'({4'b0000, ts[31:0]}));
    for (int i = 0; i < int'(spp); i++)
      check($sformatf("%s_p%0d", tag, i), 64'(wq(b + 4 + i)),
            64'({2'b00, i == int'(spp) - 1, 1'b0, s0 + 32'(i)}));
  endtask
  initial begin
    rst_n = 1'b0;
    set_stb = 1'b0;
    set_addr = '0;
    set_data = '0;
    sample = '0;
    strobe = 1'b0;
    vita_time = '0;
    rx_dst_rdy_i = 1'b1;
    repeat (3) tick();
    check("rst_data", 64'(rx_data_o), 64'd0);
    check("rst_valid", 64'(rx_src_rdy_o), 64'd0);
    check("rst_run", 64'(run), 64'd0);
    check("rst_ovf", 64'({overflow, overflow_count}), 64'd0);
    rst_n = 1'b1;
    tick();
    write_reg(8'd0, 32'd4);
    write_reg(8'd1, 32'hABCD0001);
    write_reg(8'd2, 32'd1);
    check("run_enabled", 64'(run), 64'd1);
    for (int i = 0; i < 4; i++) send(32'h11110000 + 32'(i), 64'h1_00000010 + 64'(i));
    wait_words(8);
    check_pkt("t1", 0, 4'd0, 16'd4, 32'hABCD0001, 64'h1_00000010, 32'h11110000);
    q.delete();
    rdy_mode = 1;
    for (int i = 0; i < 4; i++) send(32'h11110000 + 32'(i), 64'h1_00000010 + 64'(i));
    wait_words(8);
    check_pkt("t2", 0, 4'd1, 16'd4, 32'hABCD0001, 64'h1_00000010, 32'h11110000);
    rdy_mode = 2;
    q.delete();
    write_reg(8'd0, 32'd16);
    write_reg(8'd2, 32'd3);
    ovf_pulses = 0;
    for (int i = 0; i < 32; i++) send(32'h33000000 + 32'(i), 64'h3_00000000 + 64'(i));
    repeat (2) tick();
    check("t3_ovf_count", 64'(overflow_count), 64'd1);
    check("t3_ovf_pulses", 64'(ovf_pulses), 64'd1);
    rdy_mode = 0;
    wait_words(20);
    check_pkt("t3", 0, 4'd0, 16'd16, 32'hABCD0001, 64'h3_00000000, 32'h33000000);
    q.delete();
    write_reg(8'd0, 32'd1);
    write_reg(8'd2, 32'd3);
    for (int k = 0; k < 17; k++) begin
      send(32'h44000000 + 32'(k), 64'h4_00000000 + 64'(k));
      repeat (7) tick();
    end
    wait_words(85);
    for (int k = 0; k < 17; k++)
      check_pkt($sformatf("t4_%0d", k), 5 * k, 4'(k), 16'd1, 32'hABCD0001, 64'h4_00000000 + 64'(k),
                32'h44000000 + 32'(k));
    q.delete();
    write_reg(8'd0, 32'd8);
    write_reg(8'd2, 32'd3);
    for (int i = 0; i < 3; i++) send(32'h55000000 + 32'(i), 64'h5_00000000 + 64'(i));
    write_reg(8'd2, 32'd0);
    check("t5_run_open", 64'(run), 64'd1);
    for (int i = 3; i < 7; i++) send(32'h55000000 + 32'(i), 64'h5_00000000 + 64'(i));
    check("t5_run_before_last", 64'(run), 64'd1);
    send(32'h55000007, 64'h5_00000007);
    check("t5_run_after_last", 64'(run), 64'd0);
    send(32'h5500AAAA, 64'h5_0000AAAA);
    send(32'h5500BBBB, 64'h5_0000BBBB);
    wait_words(12);
    check_pkt("t5", 0, 4'd0, 16'd8, 32'hABCD0001, 64'h5_00000000, 32'h55000000);
    q.delete();
    rdy_mode = 2;
    write_reg(8'd0, 32'd4);
    write_reg(8'd2, 32'd3);
    for (int i = 0; i < 4; i++) send(32'h66000000 + 32'(i), 64'h6_00000000 + 64'(i));
    repeat (3) tick();
    rdy_mode = 3;
    rx_dst_rdy_i = 1'b1;
    repeat (5) tick();
    check("t6_pre_count", 64'(q.size()), 64'd5);
    check("t6_pre_word", 64'(rx_data_o), 64'(36'h0_66000001));
    rst_n = 1'b0;
    rx_dst_rdy_i = 1'b0;
    tick();
    check("t6_rst_data", 64'(rx_data_o), 64'd0);
    check("t6_rst_valid", 64'(rx_src_rdy_o), 64'd0);
    check("t6_rst_run", 64'(run), 64'd0);
    check("t6_rst_ovf", 64'({overflow, overflow_count}), 64'd0);
    rst_n = 1'b1;
    rdy_mode = 0;
    tick();
    q.delete();
    write_reg(8'd0, 32'd4);
    write_reg(8'd1, 32'h12345678);
    write_reg(8'd2, 32'd1);
    send(32'h77000000, 64'h2_00000020);
    found = 1'b0;
    for (int i = 0; i < 4 && !found; i++) begin
      found = rx_src_rdy_o && rx_data_o[SOF];
      if (!found) tick();
    end
    check("t6_hdr0_latency", 64'(found), 64'd1);
    for (int i = 1; i < 4; i++) send(32'h77000000 + 32'(i), 64'h2_00000020 + 64'(i));
    wait_words(8);
    check_pkt("t6", 0, 4'd0, 16'd4, 32'h12345678, 64'h2_00000020, 32'h77000000);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
